ex_hazard_ctrl: RTL and testbench

- Hazard and stall controller on the consumer side of the decode→execute pipeline register.
- Watches the instruction leaving decode and the instructions held in EX and MEM.
- Generates `de_stall` (load-use bubble request) and `exe_stall` (multi-cycle MUL/DIV occupancy).
- Produces registered per-operand forwarding selects aligned with the EX stage.
- Also tracks the age of those selects while the consumer is frozen in EX.

---
 rtl/ex_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// Load-use and MUL/DIV stall control with EX-aligned forwarding selects.
// Selects age while the consumer is frozen so the producer stays tracked.
module ex_hazard_ctrl #(
    parameter int MUL_STALL = 2,
    parameter int DIV_STALL = 32,
    parameter int CNT_W     = 6
) (
    input  logic       clk,
    input  logic       cpurst_n,
    input  logic       flush,
    input  logic       memacc_stall,
    input  logic       de_inst_valid,
    input  logic [4:0] de_rs1addr,
    input  logic [4:0] de_rs2addr,
    input  logic       de_rs1_used,
    input  logic       de_rs2_used,
    input  logic       ex_wr_reg,
    input  logic [4:0] ex_wr_regindex,
    input  logic       ex_load,
    input  logic       ex_md_op,
    input  logic       ex_md_is_div,
    input  logic       ex_inst_valid,
    input  logic       mem_wr_reg,
    input  logic [4:0] mem_wr_regindex,
    output logic       de_stall,
    output logic       exe_stall,
    output logic       md_busy,
    output logic       md_done,
    output logic [1:0] fwd_rs1_sel,
    output logic [1:0] fwd_rs2_sel
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Load values are N-2: the start cycle and the cnt==0 cycle both stall
    localparam logic [CNT_W-1:0] MUL_LD =
        CNT_W'(MUL_STALL >= 2 ? MUL_STALL - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LD =
        CNT_W'(DIV_STALL >= 2 ? DIV_STALL - 2 : 0);
    localparam logic MUL_ONE = (MUL_STALL == 1);
    localparam logic DIV_ONE = (DIV_STALL == 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [1:0]       r_fwd1;
    logic [1:0]       r_fwd2;
    logic             w_start;
    logic             w_stall;
    logic             w_hit1;
    logic             w_hit2;
    logic [1:0]       w_sel1;
    logic [1:0]       w_sel2;

    function automatic logic [1:0] f_sel(
        input logic       used,
        input logic [4:0] a,
        input logic       exw,
        input logic [4:0] exd,
        input logic       memw,
        input logic [4:0] memd
    );
        logic [1:0] s;
        s = 2'b00;
        if (used && exw && exd == a && exd != 5'd0)
            s = 2'b01;
        else if (used && memw && memd == a && memd != 5'd0)
            s = 2'b10;
        return s;
    endfunction

    // Producer moves one stage further away per drained cycle
    function automatic logic [1:0] f_age(input logic [1:0] s);
        return (s == 2'b01) ? 2'b10 : 2'b00;
    endfunction

    assign w_start = ex_inst_valid & ex_md_op & ~flush;

    assign exe_stall = (((r_state == S_IDLE) & w_start) |
                        (r_state == S_BUSY)) & ~flush;
    assign md_busy   = (r_state != S_IDLE);
    assign md_done   = (r_state == S_DONE) & ~flush;
    assign w_stall   = exe_stall | memacc_stall;

    assign w_hit1 = de_rs1_used & (de_rs1addr == ex_wr_regindex) &
                    (ex_wr_regindex != 5'd0);
    assign w_hit2 = de_rs2_used & (de_rs2addr == ex_wr_regindex) &
                    (ex_wr_regindex != 5'd0);
    assign de_stall = de_inst_valid & ex_inst_valid & ex_load &
                      ex_wr_reg & (w_hit1 | w_hit2) & ~flush;

    assign w_sel1 = f_sel(de_rs1_used, de_rs1addr, ex_wr_reg,
                          ex_wr_regindex, mem_wr_reg, mem_wr_regindex);
    assign w_sel2 = f_sel(de_rs2_used, de_rs2addr, ex_wr_reg,
                          ex_wr_regindex, mem_wr_reg, mem_wr_regindex);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (ex_md_is_div ? DIV_ONE : MUL_ONE) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_state_nx = S_BUSY;
                        w_cnt_nx   = ex_md_is_div ? DIV_LD : MUL_LD;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == '0)
                    w_state_nx = S_DONE;
                else
                    w_cnt_nx = r_cnt - 1'b1;
            end
            S_DONE: begin
                if (!memacc_stall)
                    w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
        if (flush) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
        end
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            r_fwd1 <= 2'b00;
            r_fwd2 <= 2'b00;
        end else if (flush) begin
            r_fwd1 <= 2'b00;
            r_fwd2 <= 2'b00;
        end else if (de_stall && !w_stall) begin
            r_fwd1 <= 2'b00;
            r_fwd2 <= 2'b00;
        end else if (!w_stall) begin
            r_fwd1 <= w_sel1;
            r_fwd2 <= w_sel2;
        end else if (exe_stall && !memacc_stall) begin
            r_fwd1 <= f_age(r_fwd1);
            r_fwd2 <= f_age(r_fwd2);
        end
    end

    assign fwd_rs1_sel = r_fwd1;
    assign fwd_rs2_sel = r_fwd2;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: decode vectors, MD sequences, random vs model.
module tb_ex_hazard_ctrl;

    localparam int MS = 2;
    localparam int DS = 32;

    logic       clk = 1'b0;
    logic       cpurst_n, flush, memacc_stall, de_inst_valid;
    logic [4:0] de_rs1addr, de_rs2addr;
    logic       de_rs1_used, de_rs2_used, ex_wr_reg;
    logic [4:0] ex_wr_regindex;
    logic       ex_load, ex_md_op, ex_md_is_div, ex_inst_valid;
    logic       mem_wr_reg;
    logic [4:0] mem_wr_regindex;
    logic       de_stall, exe_stall, md_busy, md_done;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;

    int total = 0;
    int bad   = 0;

    ex_hazard_ctrl #(.MUL_STALL(MS), .DIV_STALL(DS), .CNT_W(6)) dut (
        .clk(clk), .cpurst_n(cpurst_n), .flush(flush),
        .memacc_stall(memacc_stall), .de_inst_valid(de_inst_valid),
        .de_rs1addr(de_rs1addr), .de_rs2addr(de_rs2addr),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .ex_wr_reg(ex_wr_reg), .ex_wr_regindex(ex_wr_regindex),
        .ex_load(ex_load), .ex_md_op(ex_md_op),
        .ex_md_is_div(ex_md_is_div), .ex_inst_valid(ex_inst_valid),
        .mem_wr_reg(mem_wr_reg), .mem_wr_regindex(mem_wr_regindex),
        .de_stall(de_stall), .exe_stall(exe_stall), .md_busy(md_busy),
        .md_done(md_done), .fwd_rs1_sel(fwd_rs1_sel),
        .fwd_rs2_sel(fwd_rs2_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [4:0] r1, r2;
        logic       u1, u2, exw;
        logic [4:0] exd;
        logic       ld, exv, memw;
        logic [4:0] memd;
        logic       fl;
        logic       e_st;
        logic [1:0] e_f1, e_f2;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        flush = 0; memacc_stall = 0; de_inst_valid = 0;
        de_rs1addr = 0; de_rs2addr = 0; de_rs1_used = 0; de_rs2_used = 0;
        ex_wr_reg = 0; ex_wr_regindex = 0; ex_load = 0; ex_md_op = 0;
        ex_md_is_div = 0; ex_inst_valid = 0;
        mem_wr_reg = 0; mem_wr_regindex = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cpurst_n = 0;
        idle_in();
        #12;
        @(posedge clk);
        #1 cpurst_n = 1;
    endtask

    function automatic logic [7:0] outs();
        return {de_stall, exe_stall, md_busy, md_done,
                fwd_rs1_sel, fwd_rs2_sel};
    endfunction

    function automatic logic [1:0] ref_sel(
        input logic used, input logic [4:0] a, input logic exw,
        input logic [4:0] exd, input logic memw, input logic [4:0] memd);
        if (!used || a == 0) return 2'b00;
        if (exw && exd == a) return 2'b01;
        if (memw && memd == a) return 2'b10;
        return 2'b00;
    endfunction

    // Select tracks where the producer is: EX->MEM (01), MEM->WB (10), gone
    function automatic logic [1:0] ref_age(input logic [1:0] s);
        case (s)
            2'b01:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    int         m_left;
    bit         m_done;
    logic [1:0] m_f1, m_f2;

    initial begin
        logic [1:0] exp_age[3];
        int ms_cnt, ds_cnt, first_ds, d1, d2, npulse;

        tv[0]  = '{1,5,1,1,1,1,5,1,1,0,0,0, 1,2'b00,2'b00};
        tv[1]  = '{1,5,1,1,1,0,0,0,0,1,5,0, 0,2'b10,2'b00};
        tv[2]  = '{1,0,1,1,1,1,0,1,1,1,0,0, 0,2'b00,2'b00};
        tv[3]  = '{1,3,7,1,0,1,7,1,1,0,0,0, 0,2'b00,2'b00};
        tv[4]  = '{1,4,6,1,1,1,4,0,1,1,4,0, 0,2'b01,2'b00};
        tv[5]  = '{1,2,9,1,1,0,9,0,1,1,9,0, 0,2'b00,2'b10};
        tv[6]  = '{1,5,5,1,1,1,5,1,1,0,0,1, 0,2'b00,2'b00};
        tv[7]  = '{0,5,1,1,1,1,5,1,1,0,0,0, 0,2'b01,2'b00};
        tv[8]  = '{1,5,1,1,1,1,5,1,0,0,0,0, 0,2'b01,2'b00};
        tv[9]  = '{1,5,1,1,1,0,5,1,1,0,0,0, 0,2'b00,2'b00};
        tv[10] = '{1,2,3,1,1,1,2,0,1,1,3,0, 0,2'b01,2'b10};
        tv[11] = '{1,8,8,0,1,1,8,1,1,1,8,0, 1,2'b00,2'b00};
        tv[12] = '{1,8,8,0,0,1,8,1,1,1,8,0, 0,2'b00,2'b00};
        exp_age = '{2'b10, 2'b00, 2'b00};

        cpurst_n = 0;
        idle_in();
        #3;
        chk("reset_outs", outs(), 8'h00);
        do_reset();
        chk("post_reset", outs(), 8'h00);

        for (int i = 0; i < 13; i++) begin
            de_inst_valid = tv[i].dv;
            de_rs1addr = tv[i].r1; de_rs2addr = tv[i].r2;
            de_rs1_used = tv[i].u1; de_rs2_used = tv[i].u2;
            ex_wr_reg = tv[i].exw; ex_wr_regindex = tv[i].exd;
            ex_load = tv[i].ld; ex_inst_valid = tv[i].exv;
            mem_wr_reg = tv[i].memw; mem_wr_regindex = tv[i].memd;
            flush = tv[i].fl;
            @(negedge clk);
            chk($sformatf("vec%0d_de_stall", i), 8'(de_stall),
                8'(tv[i].e_st));
            tick();
            chk($sformatf("vec%0d_fwd", i),
                8'({fwd_rs1_sel, fwd_rs2_sel}),
                8'({tv[i].e_f1, tv[i].e_f2}));
        end

        // MUL then DIV back-to-back
        do_reset();
        ms_cnt = 0; ds_cnt = 0; first_ds = 0; d1 = 0; d2 = 0; npulse = 0;
        for (int k = 1; k <= 40; k++) begin
            ex_inst_valid = 1;
            ex_md_op = (k <= 36);
            ex_md_is_div = (k >= 4);
            @(negedge clk);
            if (exe_stall) begin
                if (k <= 3) ms_cnt++;
                else begin
                    ds_cnt++;
                    if (first_ds == 0) first_ds = k;
                end
            end
            if (md_done) begin
                npulse++;
                if (k <= 3 && d1 == 0) d1 = k;
                if (k > 3 && d2 == 0) d2 = k;
            end
            tick();
        end
        chk("mul_stall_cycles", 8'(ms_cnt), 8'(MS));
        chk("mul_done_cycle", 8'(d1), 8'd3);
        chk("div_stall_start", 8'(first_ds), 8'd4);
        chk("div_stall_cycles", 8'(ds_cnt), 8'(DS));
        chk("div_done_cycle", 8'(d2), 8'd36);
        chk("md_done_pulses", 8'(npulse), 8'd2);

        // Frozen consumer aging, then flush mid-BUSY at cnt=10
        do_reset();
        de_inst_valid = 1; de_rs1addr = 8; de_rs1_used = 1;
        ex_wr_reg = 1; ex_wr_regindex = 8; ex_inst_valid = 1;
        tick();
        chk("age_start", 8'(fwd_rs1_sel), 8'(2'b01));
        ex_md_op = 1; ex_md_is_div = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("age_step%0d", i), 8'(fwd_rs1_sel),
                8'(exp_age[i]));
        end
        repeat (18) tick();
        chk("busy_before_flush", 8'({exe_stall, md_busy}), 8'b11);
        flush = 1;
        #1;
        chk("flush_same_cycle", 8'({exe_stall, md_done}), 8'b00);
        tick();
        flush = 0; ex_md_op = 0;
        #1;
        chk("flush_next_idle", 8'({md_busy, exe_stall}), 8'b00);

        // memacc_stall through BUSY and DONE
        do_reset();
        de_inst_valid = 1; de_rs1addr = 8; de_rs1_used = 1;
        ex_wr_reg = 1; ex_wr_regindex = 8; ex_inst_valid = 1;
        tick();
        for (int k = 1; k <= 6; k++) begin
            ex_md_op = (k <= 5);
            memacc_stall = (k <= 4);
            @(negedge clk);
            chk($sformatf("memacc_k%0d_done", k), 8'(md_done),
                8'((k >= 3 && k <= 5) ? 1 : 0));
            chk($sformatf("memacc_k%0d_exe", k), 8'(exe_stall),
                8'((k <= 2) ? 1 : 0));
            if (k == 6) chk("memacc_idle", 8'(md_busy), 8'd0);
            tick();
            if (k <= 4)
                chk($sformatf("memacc_k%0d_hold", k),
                    8'({fwd_rs1_sel, fwd_rs2_sel}), 8'(4'b0100));
        end

        // Async reset mid-BUSY
        do_reset();
        ex_inst_valid = 1; ex_md_op = 1; ex_md_is_div = 1;
        repeat (5) tick();
        #2;
        cpurst_n = 0;
        idle_in();
        #1;
        chk("async_reset_outs", outs(), 8'h00);
        @(posedge clk);
        #1 cpurst_n = 1;
        npulse = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_done) npulse++;
        end
        chk("no_done_after_reset", 8'(npulse), 8'd0);

        // Randomized run against the reference model
        do_reset();
        m_left = 0; m_done = 0; m_f1 = 0; m_f2 = 0;
        for (int c = 0; c < 3000; c++) begin
            logic h1, h2, e_ds, e_ex, e_bz, e_dn, st, stl;
            logic [1:0] s1, s2;
            flush = ($urandom_range(0, 31) == 0);
            memacc_stall = ($urandom_range(0, 3) == 0);
            de_inst_valid = ($urandom_range(0, 3) != 0);
            de_rs1addr = 5'($urandom_range(0, 3));
            de_rs2addr = 5'($urandom_range(0, 3));
            de_rs1_used = 1'($urandom);
            de_rs2_used = 1'($urandom);
            ex_wr_reg = 1'($urandom);
            ex_wr_regindex = 5'($urandom_range(0, 3));
            ex_load = 1'($urandom);
            ex_md_op = ($urandom_range(0, 7) == 0);
            ex_md_is_div = ($urandom_range(0, 3) == 0);
            ex_inst_valid = ($urandom_range(0, 3) != 0);
            mem_wr_reg = 1'($urandom);
            mem_wr_regindex = 5'($urandom_range(0, 3));
            @(negedge clk);
            h1 = de_rs1_used && de_rs1addr == ex_wr_regindex &&
                 ex_wr_regindex != 0;
            h2 = de_rs2_used && de_rs2addr == ex_wr_regindex &&
                 ex_wr_regindex != 0;
            e_ds = de_inst_valid && ex_inst_valid && ex_load &&
                   ex_wr_reg && (h1 || h2) && !flush;
            st = 0;
            if (m_left > 0) begin
                e_ex = !flush; e_bz = 1; e_dn = 0;
            end else if (m_done) begin
                e_ex = 0; e_bz = 1; e_dn = !flush;
            end else begin
                st = ex_inst_valid && ex_md_op && !flush;
                e_ex = st; e_bz = 0; e_dn = 0;
            end
            chk($sformatf("rand%0d", c), outs(),
                {e_ds, e_ex, e_bz, e_dn, m_f1, m_f2});
            stl = e_ex || memacc_stall;
            s1 = ref_sel(de_rs1_used, de_rs1addr, ex_wr_reg,
                         ex_wr_regindex, mem_wr_reg, mem_wr_regindex);
            s2 = ref_sel(de_rs2_used, de_rs2addr, ex_wr_reg,
                         ex_wr_regindex, mem_wr_reg, mem_wr_regindex);
            if (flush || (e_ds && !stl)) begin
                m_f1 = 0; m_f2 = 0;
            end else if (!stl) begin
                m_f1 = s1; m_f2 = s2;
            end else if (e_ex && !memacc_stall) begin
                m_f1 = ref_age(m_f1); m_f2 = ref_age(m_f2);
            end
            if (flush) begin
                m_left = 0; m_done = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_done = 1;
            end else if (m_done) begin
                if (!memacc_stall) m_done = 0;
            end else if (st) begin
                m_left = (ex_md_is_div ? DS : MS) - 1;
                if (m_left == 0) m_done = 1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
